// File: rtl/delta_stream_reconstructor_pkg.sv
// Shared widths and signed limits for the delta reconstruction datapath.
// Constants only; no logic.
package delta_stream_reconstructor_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int INDEX_W   = 8;

    localparam logic [WIDTH_DEF-1:0] SMAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    localparam logic [WIDTH_DEF-1:0] SMIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/delta_stream_reconstructor_adder.sv
// WIDTH-bit two's complement adder made of chained 4-bit slices, carry-in 0.
// Purely combinational; reports signed overflow alongside the wrapped sum.
module signed_ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 4;

    logic [NSLICE-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        if (i == NSLICE - 1) begin : g_top
            // The top slice's carry-out carries no information for a signed result.
            assign sum[4*i +: 4] = a[4*i +: 4] + b[4*i +: 4] + {3'b000, carry[i]};
        end else begin : g_mid
            logic [4:0] part;
            assign part            = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, carry[i]};
            assign sum[4*i +: 4]   = part[3:0];
            assign carry[i+1]      = part[4];
        end
    end

    assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/delta_stream_reconstructor.sv
// Rebuilds absolute samples from a seed plus signed deltas; one cycle accept-to-output.
// in_ready = !out_valid || out_ready, so a held output stalls the input without bubbles.
module delta_stream_reconstructor
    import delta_stream_reconstructor_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter bit SATURATE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic [WIDTH-1:0]   in_delta,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sample,
    output logic               out_ovf,
    output logic [INDEX_W-1:0] out_index
);

    localparam logic [WIDTH-1:0] SMAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   sum;
    logic               ovf;
    logic [WIDTH-1:0]   result;
    logic [INDEX_W-1:0] idx;
    logic               accept;

    signed_ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .a   (acc),
        .b   (in_delta),
        .sum (sum),
        .ovf (ovf)
    );

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_index = idx;

    always_comb begin
        result = sum;
        // Clamp direction follows the accumulator sign: overflow only happens when both operands share it.
        if (SATURATE && ovf) begin
            result = acc[WIDTH-1] ? SMIN_W : SMAX_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_ovf    <= 1'b0;
            idx        <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (in_first) begin
                acc        <= in_delta;
                out_sample <= in_delta;
                out_ovf    <= 1'b0;
                idx        <= '0;
            end else begin
                acc        <= result;
                out_sample <= result;
                out_ovf    <= ovf;
                idx        <= idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_delta_stream_reconstructor.sv
// Directed bench driving a wrapping and a saturating instance with identical stimulus.
module tb_delta_stream_reconstructor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_first;
    logic [7:0] in_delta;
    logic       out_ready;

    logic       w_in_ready, w_out_valid, w_out_ovf;
    logic [7:0] w_out_sample, w_out_index;
    logic       s_in_ready, s_out_valid, s_out_ovf;
    logic [7:0] s_out_sample, s_out_index;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    delta_stream_reconstructor #(.WIDTH(8), .SATURATE(1'b0)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (w_in_ready),
        .in_first   (in_first),
        .in_delta   (in_delta),
        .out_valid  (w_out_valid),
        .out_ready  (out_ready),
        .out_sample (w_out_sample),
        .out_ovf    (w_out_ovf),
        .out_index  (w_out_index)
    );

    delta_stream_reconstructor #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_first   (in_first),
        .in_delta   (in_delta),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_sample (s_out_sample),
        .out_ovf    (s_out_ovf),
        .out_index  (s_out_index)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted word, then the input goes quiet unless the caller drives again.
    task automatic push(input logic first, input logic [7:0] delta);
        in_valid = 1'b1;
        in_first = first;
        in_delta = delta;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_delta = 8'hxx;
    endtask

    task automatic both(input string tag, input logic [7:0] ws, input logic wo,
                        input logic [7:0] ss, input logic so, input logic [7:0] ix);
        chk({tag, " wrap valid"},  {7'd0, w_out_valid}, 8'd1);
        chk({tag, " wrap sample"}, w_out_sample, ws);
        chk({tag, " wrap ovf"},    {7'd0, w_out_ovf}, {7'd0, wo});
        chk({tag, " wrap index"},  w_out_index, ix);
        chk({tag, " sat valid"},   {7'd0, s_out_valid}, 8'd1);
        chk({tag, " sat sample"},  s_out_sample, ss);
        chk({tag, " sat ovf"},     {7'd0, s_out_ovf}, {7'd0, so});
        chk({tag, " sat index"},   s_out_index, ix);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_delta  = 8'd0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset out_valid", {7'd0, w_out_valid}, 8'd0);
        chk("reset out_sample", w_out_sample, 8'd0);
        chk("reset out_ovf", {7'd0, w_out_ovf}, 8'd0);
        chk("reset out_index", w_out_index, 8'd0);
        chk("reset in_ready", {7'd0, w_in_ready}, 8'd1);
        chk("reset sat in_ready", {7'd0, s_in_ready}, 8'd1);

        // Basic stream, back to back.
        out_ready = 1'b1;
        push(1'b1, 8'd10);      both("seed10", 8'd10, 1'b0, 8'd10, 1'b0, 8'd0);
        push(1'b0, 8'd5);       both("d+5",    8'd15, 1'b0, 8'd15, 1'b0, 8'd1);
        push(1'b0, 8'(-3));     both("d-3",    8'd12, 1'b0, 8'd12, 1'b0, 8'd2);
        push(1'b0, 8'd0);       both("d+0",    8'd12, 1'b0, 8'd12, 1'b0, 8'd3);
        tick();
        chk("drain out_valid", {7'd0, w_out_valid}, 8'd0);

        // Positive overflow: wrap gives -126, clamp gives 127; -7 then lands on 123 / 120.
        push(1'b1, 8'd120);     both("seed120", 8'd120, 1'b0, 8'd120, 1'b0, 8'd0);
        push(1'b0, 8'd10);      both("pos ovf", 8'(-126), 1'b1, 8'd127, 1'b1, 8'd1);
        push(1'b0, 8'(-7));     both("after clamp", 8'd123, 1'b1, 8'd120, 1'b0, 8'd2);

        // Negative overflow: -100 - 50 wraps to 106, clamps to -128.
        push(1'b1, 8'(-100));   both("seed-100", 8'(-100), 1'b0, 8'(-100), 1'b0, 8'd0);
        push(1'b0, 8'(-50));    both("neg ovf", 8'd106, 1'b1, 8'(-128), 1'b1, 8'd1);
        tick();

        // Backpressure: output held three cycles while a delta waits.
        out_ready = 1'b0;
        push(1'b1, 8'd20);      both("bp seed", 8'd20, 1'b0, 8'd20, 1'b0, 8'd0);
        in_valid = 1'b1;
        in_first = 1'b0;
        in_delta = 8'd3;
        for (int c = 0; c < 3; c++) begin
            chk("bp in_ready low", {7'd0, w_in_ready}, 8'd0);
            tick();
            both("bp hold", 8'd20, 1'b0, 8'd20, 1'b0, 8'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready release", {7'd0, w_in_ready}, 8'd1);
        tick();
        in_valid = 1'b0;
        both("bp release", 8'd23, 1'b0, 8'd23, 1'b0, 8'd1);
        tick();

        // 300 consecutive +1 deltas after seed 0.
        push(1'b1, 8'd0);       both("run seed", 8'd0, 1'b0, 8'd0, 1'b0, 8'd0);
        in_valid = 1'b1;
        in_first = 1'b0;
        in_delta = 8'd1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            both("run", 8'(k), (k % 256) == 128, (k > 127) ? 8'd127 : 8'(k), k >= 128, 8'(k));
        end
        in_valid = 1'b0;

        // Reset while a sample is stalled at the output.
        out_ready = 1'b0;
        tick();
        chk("pre-reset out_valid", {7'd0, w_out_valid}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid reset out_valid", {7'd0, w_out_valid}, 8'd0);
        chk("mid reset out_sample", w_out_sample, 8'd0);
        chk("mid reset out_index", w_out_index, 8'd0);
        chk("mid reset sat out_valid", {7'd0, s_out_valid}, 8'd0);
        chk("mid reset sat out_sample", s_out_sample, 8'd0);
        out_ready = 1'b1;
        push(1'b0, 8'd4);       both("unseeded", 8'd4, 1'b0, 8'd4, 1'b0, 8'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
